mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//  Multi-cycle shift-add multiplier and sequencer for the RV64 MUL/MULH* path.
//  Latches operands when the decoder flags a multiply (funct7[0]=1, R-type), iterates one bit per cycle,
//  and holds the PC via stall until the product is ready. On the done cycle the product goes to the
//  regfile writeback mux in place of the ALU result.
// PARAMETERS
//  DATA_W  64                     operand/result width
//  CNT_W   $clog2(DATA_W)+1       iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  arst       in   1       asynchronous, active-high reset
//  start      in   1       multiply request (decoded MUL*, CPU enabled)
//  flush      in   1       synchronous abort of an in-flight multiply
//  op_a       in   DATA_W  multiplicand (rs1)
//  op_b       in   DATA_W  multiplier (rs2)
//  signed_a   in   1       treat op_a as two's complement
//  signed_b   in   1       treat op_b as two's complement
//  hi_sel     in   1       1: return product[2W-1:W] (MULH*); 0: product[W-1:0] (MUL)
//  busy       out  1       state != IDLE
//  stall      out  1       hold PC/regfile write: (IDLE & start) | RUN; combinational
//  done       out  1       one-cycle pulse; result valid this cycle only
//  result     out  DATA_W  selected product half; registered
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on start, latch mcand={W'0,|op_a|}, mplier=|op_b|, prod=0, neg=(signed_a&op_a[W-1])^(signed_b&op_b[W-1]),
//         hi latched from hi_sel, cnt=0; go RUN. Inputs are ignored outside this IDLE+start cycle.
//   RUN:  each cycle: if mplier[0] then prod+=mcand; mcand<<=1; mplier>>=1; cnt++.
//         Go DONE after the DATA_W-th iteration (cnt==DATA_W-1 at that edge).
//   DONE: done=1; result = hi ? P[2W-1:W] : P[W-1:0], where P = neg ? -prod : prod (2W-bit two's complement).
//         stall=0 so the CPU retires; start ignored; unconditionally go IDLE next cycle.
//  Latency: start sampled at edge 0; done high in cycle DATA_W+1 (65 for W=64) without early termination.
//  |x| is the W-bit unsigned magnitude; most-negative input gives 2^(W-1), no overflow (P is 2W bits).
//  Unsigned mode with op MSB=1: the magnitude is the raw value.
//  start during RUN/DONE: ignored, no queueing.
//  flush: in RUN -> IDLE next edge with no done pulse; result holds its old value. In DONE: done still pulses.
//  flush & start in IDLE: flush wins, stay IDLE.
//  result holds its last value between operations.
// CONFIGURATION
//  MULT_EARLY_TERM_EN defined: in RUN, if the next mplier value (after this cycle's shift) is 0, go DONE at
//   this edge. Latency = 1 + max(1, index of highest set bit of |op_b| + 1) cycles to done.
//   op_b=0 -> done in cycle 2.
//  Undefined: fixed DATA_W iterations; the zero-detect logic is absent. Results are identical in both modes.
// STRUCTURE
//  Package mult_pkg: state enum (MS_IDLE, MS_RUN, MS_DONE), MULT_DATA_W default, CNT_W function.
//  One sub-module, mult_abs_sign: combinational magnitude of an operand plus its sign bit; instanced twice.
//  The FSM, datapath registers and output select are in mult_seq_ctrl.
// TESTING (DATA_W=64, macro undefined unless stated)
//  start, a=3, b=5, unsigned, hi_sel=0 -> stall high cycles 0..64; done only in cycle 65; result=15.
//  a=-2, b=3, signed both, hi_sel=1 -> result=64'hFFFF_FFFF_FFFF_FFFF; hi_sel=0 -> 64'hFFFF_FFFF_FFFF_FFFA.
//  a=b=64'hFFFF_FFFF_FFFF_FFFF, unsigned, hi_sel=1 -> 64'hFFFF_FFFF_FFFF_FFFE; hi_sel=0 -> 1.
//  a=64'h8000_0000_0000_0000, b=-1, signed both, hi_sel=0 -> 64'h8000_0000_0000_0000; hi_sel=1 -> 0.
//  flush in cycle 10 of RUN; start reasserted in cycle 12 -> no done for the first op; second completes in cycle 77.
//  arst in cycle 30 -> outputs 0 at once; IDLE. MULT_EARLY_TERM_EN defined: a=7, b=2 -> done in cycle 3, result=14.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

  localparam int unsigned MULT_DATA_W = 64;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } mult_state_e;

  // Counter must hold DATA_W-1 with headroom for the terminal increment.
  function automatic int unsigned cnt_w(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/mult_abs_sign.sv
// Combinational unsigned magnitude and sign of one multiplier operand.
module mult_abs_sign
  import mult_pkg::*;
#(
  parameter int unsigned DATA_W = MULT_DATA_W
) (
  input  logic [DATA_W-1:0] op,
  input  logic              is_signed,
  output logic [DATA_W-1:0] mag,
  output logic              sign
);

  // The most-negative value negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    sign = is_signed & op[DATA_W-1];
    mag  = sign ? -op : op;
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle shift-add multiplier and pipeline stall sequencer for MUL/MULH*.
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned DATA_W = MULT_DATA_W
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              signed_a,
  input  logic              signed_b,
  input  logic              hi_sel,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned CNT_W  = cnt_w(DATA_W);
  localparam int unsigned PROD_W = 2 * DATA_W;

  mult_state_e state_q, state_d;

  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [PROD_W-1:0] prod_step, prod_fix;
  logic [DATA_W-1:0] mplier_q, mplier_d, mplier_shift;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              hi_q, hi_d;
  logic              sign_a, sign_b;
  logic              accept, last_iter, finish;

  mult_abs_sign #(
    .DATA_W(DATA_W)
  ) u_abs_a (
    .op       (op_a),
    .is_signed(signed_a),
    .mag      (mag_a),
    .sign     (sign_a)
  );

  mult_abs_sign #(
    .DATA_W(DATA_W)
  ) u_abs_b (
    .op       (op_b),
    .is_signed(signed_b),
    .mag      (mag_b),
    .sign     (sign_b)
  );

  assign mplier_shift = {1'b0, mplier_q[DATA_W-1:1]};
  assign prod_step    = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_fix     = neg_q ? -prod_step : prod_step;

  // Flush beats start so a killed instruction never launches a multiply.
  assign accept = (state_q == MS_IDLE) && start && !flush;

`ifdef MULT_EARLY_TERM_EN
  assign last_iter = (mplier_shift == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));
`endif

  assign finish = (state_q == MS_RUN) && last_iter && !flush;

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= MS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MS_IDLE: if (accept) state_d = MS_RUN;
      MS_RUN: begin
        if (flush) begin
          state_d = MS_IDLE;
        end else if (last_iter) begin
          state_d = MS_DONE;
        end
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy  = (state_q != MS_IDLE);
    stall = ((state_q == MS_IDLE) && start) || (state_q == MS_RUN);
    done  = (state_q == MS_DONE);
  end

  // Datapath next-state
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    if (accept) begin
      mcand_d  = {{DATA_W{1'b0}}, mag_a};
      mplier_d = mag_b;
      prod_d   = '0;
      cnt_d    = '0;
      neg_d    = sign_a ^ sign_b;
      hi_d     = hi_sel;
    end else if (state_q == MS_RUN) begin
      mcand_d  = {mcand_q[PROD_W-2:0], 1'b0};
      mplier_d = mplier_shift;
      prod_d   = prod_step;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Result is captured on the final iteration so it is valid throughout the done cycle.
  always_comb begin
    result_d = result_q;
    if (finish) begin
      result_d = hi_q ? prod_fix[PROD_W-1:DATA_W] : prod_fix[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      result_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
